// File: rtl/id_ex_skid_reg_pkg.sv
// Shared types and defaults for the ID->EX skid pipeline register.
package id_ex_skid_reg_pkg;

   // Occupancy of the stage: nothing held, main slot held, main and skid held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   // Bubble defaults loaded on reset, flush and drain.
   localparam logic [31:0] DEF_RESET_PC8 = 32'h0000_3000;
   localparam logic [31:0] DEF_NOP_INS   = 32'h0000_0000;

   // Payload is packed as {ins, pc8, ext, rd2, rd1}, rd1 in the low bits.
   localparam int PAYLOAD_FIELDS = 5;

endpackage : id_ex_skid_reg_pkg

// File: rtl/id_ex_skid_reg_if.sv
// Handshake and payload bundle between ID, the ID->EX register and EX.
interface id_ex_skid_reg_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_rd1;
   logic [DATA_W-1:0] in_rd2;
   logic [DATA_W-1:0] in_ext;
   logic [DATA_W-1:0] in_pc8;
   logic [DATA_W-1:0] in_ins;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_rd1;
   logic [DATA_W-1:0] out_rd2;
   logic [DATA_W-1:0] out_ext;
   logic [DATA_W-1:0] out_pc8;
   logic [DATA_W-1:0] out_ins;
   logic [CNT_W-1:0]  stall_cnt;

   // The pipeline register itself.
   modport slave (
      input  flush, in_valid, in_rd1, in_rd2, in_ext, in_pc8, in_ins, out_ready,
      output in_ready, out_valid, out_rd1, out_rd2, out_ext, out_pc8, out_ins, stall_cnt
   );

   // The surrounding pipeline (ID producer plus EX consumer).
   modport master (
      output flush, in_valid, in_rd1, in_rd2, in_ext, in_pc8, in_ins, out_ready,
      input  in_ready, out_valid, out_rd1, out_rd2, out_ext, out_pc8, out_ins, stall_cnt
   );
endinterface : id_ex_skid_reg_if

// File: rtl/id_ex_skid_reg_payload_slot.sv
// One payload slot (rd1, rd2, ext, pc8, ins) with load and clear-to-bubble.
module id_ex_skid_reg_payload_slot
   import id_ex_skid_reg_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_PC8 = DATA_W'(DEF_RESET_PC8),
   parameter logic [DATA_W-1:0] NOP_INS   = DATA_W'(DEF_NOP_INS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic                             clear,
   input  logic [PAYLOAD_FIELDS*DATA_W-1:0] d,
   output logic [PAYLOAD_FIELDS*DATA_W-1:0] q
);
   localparam int PW = PAYLOAD_FIELDS * DATA_W;
   localparam logic [PW-1:0] BUBBLE = {NOP_INS, RESET_PC8, {(3*DATA_W){1'b0}}};

   logic [PW-1:0] slot_r;

   // Slot storage: bubble on reset/clear, new payload on load, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         slot_r <= BUBBLE;
      end else if (load) begin
         slot_r <= d;
      end else begin
         slot_r <= slot_r;
      end
   end

   assign q = slot_r;

endmodule : id_ex_skid_reg_payload_slot

// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with a two-entry skid buffer, flush and stall counter.
// in_ready and out_valid come straight from flops so EX back-pressure never
// reaches ID combinationally.
module id_ex_skid_reg
   import id_ex_skid_reg_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_PC8 = DATA_W'(DEF_RESET_PC8),
   parameter logic [DATA_W-1:0] NOP_INS   = DATA_W'(DEF_NOP_INS),
   parameter int                CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   id_ex_skid_reg_if.slave     bus
);
   localparam int PW = PAYLOAD_FIELDS * DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_r;
   state_e           state_nxt_s;
   logic             out_valid_r;
   logic             in_ready_r;
   logic [CNT_W-1:0] stall_cnt_r;

   logic             in_fire_s;
   logic             out_fire_s;
   logic             main_load_s;
   logic             main_clear_s;
   logic             main_from_skid_s;
   logic             skid_load_s;
   logic             skid_clear_s;
   logic [PW-1:0]    in_payload_s;
   logic [PW-1:0]    main_d_s;
   logic [PW-1:0]    main_q_s;
   logic [PW-1:0]    skid_q_s;

   assign in_payload_s = {bus.in_ins, bus.in_pc8, bus.in_ext, bus.in_rd2, bus.in_rd1};
   assign in_fire_s    = bus.in_valid & in_ready_r;
   assign out_fire_s   = out_valid_r & bus.out_ready;

   // Next state and slot controls; flush overrides every handshake.
   always_comb begin
      state_nxt_s      = state_r;
      main_load_s      = 1'b0;
      main_clear_s     = 1'b0;
      main_from_skid_s = 1'b0;
      skid_load_s      = 1'b0;
      skid_clear_s     = 1'b0;
      if (bus.flush) begin
         state_nxt_s  = ST_EMPTY;
         main_clear_s = 1'b1;
         skid_clear_s = 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_FULL;
                  main_load_s = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s && bus.out_ready) begin
                  state_nxt_s = ST_FULL;
                  main_load_s = 1'b1;
               end else if (in_fire_s) begin
                  state_nxt_s = ST_SKID;
                  skid_load_s = 1'b1;
               end else if (out_fire_s) begin
                  state_nxt_s  = ST_EMPTY;
                  main_clear_s = 1'b1;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_SKID: begin
               if (out_fire_s) begin
                  state_nxt_s      = ST_FULL;
                  main_load_s      = 1'b1;
                  main_from_skid_s = 1'b1;
                  skid_clear_s     = 1'b1;
               end else begin
                  state_nxt_s = ST_SKID;
               end
            end
            default: begin
               state_nxt_s  = ST_EMPTY;
               main_clear_s = 1'b1;
               skid_clear_s = 1'b1;
            end
         endcase
      end
   end

   // Main slot source: the skid entry when draining it, otherwise ID.
   always_comb begin
      main_d_s = in_payload_s;
      if (main_from_skid_s) begin
         main_d_s = skid_q_s;
      end else begin
         main_d_s = in_payload_s;
      end
   end

   // State register plus handshake flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         in_ready_r  <= (state_nxt_s != ST_SKID);
      end
   end

   // Saturating count of cycles EX stalls a valid payload; flush cycles do not count.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !bus.out_ready && !bus.flush && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   id_ex_skid_reg_payload_slot #(
      .DATA_W    (DATA_W),
      .RESET_PC8 (RESET_PC8),
      .NOP_INS   (NOP_INS)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load_s),
      .clear (main_clear_s),
      .d     (main_d_s),
      .q     (main_q_s)
   );

   id_ex_skid_reg_payload_slot #(
      .DATA_W    (DATA_W),
      .RESET_PC8 (RESET_PC8),
      .NOP_INS   (NOP_INS)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load_s),
      .clear (skid_clear_s),
      .d     (in_payload_s),
      .q     (skid_q_s)
   );

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.stall_cnt = stall_cnt_r;
   assign bus.out_rd1   = main_q_s[0*DATA_W +: DATA_W];
   assign bus.out_rd2   = main_q_s[1*DATA_W +: DATA_W];
   assign bus.out_ext   = main_q_s[2*DATA_W +: DATA_W];
   assign bus.out_pc8   = main_q_s[3*DATA_W +: DATA_W];
   assign bus.out_ins   = main_q_s[4*DATA_W +: DATA_W];

endmodule : id_ex_skid_reg
